// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared opcodes, immediate formats, FSM states and select encodings
package rv_ctrl_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [2:0] IMMI = 3'b000;
  localparam logic [2:0] IMMU = 3'b001;
  localparam logic [2:0] IMMS = 3'b010;
  localparam logic [2:0] IMMB = 3'b011;
  localparam logic [2:0] IMMJ = 3'b100;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  typedef enum logic [1:0] {PC_PLUS4 = 2'b00, PC_IMM = 2'b01, PC_ALU = 2'b10} pc_sel_t;
  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC4 = 2'b10} wb_sel_t;
  typedef enum logic [3:0] {
    C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE, C_OPIMM, C_OP, C_ILL
  } cls_t;
endpackage

// File: rtl/multicycle_ctrl_opdecode.sv
// ctrl_opdecode: combinational opcode classifier producing class, immediate format and legality
module ctrl_opdecode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_t       cls,
  output logic [2:0] extop,
  output logic       legal
);
  // map the opcode to its class, then derive the immediate format from the class
  always_comb begin
    cls = C_ILL;
    case (opcode)
      OP_LUI:    cls = C_LUI;
      OP_AUIPC:  cls = C_AUIPC;
      OP_JAL:    cls = C_JAL;
      OP_JALR:   cls = C_JALR;
      OP_BRANCH: cls = C_BRANCH;
      OP_LOAD:   cls = C_LOAD;
      OP_STORE:  cls = C_STORE;
      OP_OPIMM:  cls = C_OPIMM;
      OP_OP:     cls = C_OP;
      default:   cls = C_ILL;
    endcase
    extop = (cls == C_LUI || cls == C_AUIPC) ? IMMU :
            cls == C_JAL    ? IMMJ :
            cls == C_BRANCH ? IMMB :
            cls == C_STORE  ? IMMS : IMMI;
    legal = cls != C_ILL;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the multicycle RV32I core
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter state_t      RESET_STATE = FETCH,
  parameter int unsigned STALL_LIMIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        br_taken,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [2:0]  extop,
  output logic        alusrc_a,
  output logic        alusrc_b,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic        mem_timeout
);
  state_t      state_q, state_d;
  cls_t        cls_q, cls_d, dec_cls;
  logic [2:0]  extop_q, extop_d, dec_extop;
  logic        dec_legal;
  logic [31:0] stall_q, stall_d;
  logic        waiting;
  logic        unused_instr;

  assign unused_instr = ^instr[31:7];

  ctrl_opdecode u_dec (
    .opcode(instr[6:0]),
    .cls   (dec_cls),
    .extop (dec_extop),
    .legal (dec_legal)
  );

  // next state and control outputs; reset forces every strobe and request low
  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    extop_d  = extop_q;
    extop    = rst ? IMMI : extop_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_PLUS4;
    alusrc_a = 1'b0;
    alusrc_b = 1'b0;
    reg_we   = 1'b0;
    wb_sel   = WB_ALU;
    illegal  = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
          state_d  = imem_ack ? DECODE : FETCH;
        end
        DECODE: begin
          cls_d   = dec_cls;
          extop_d = dec_extop;
          extop   = dec_extop;
          illegal = !dec_legal;
          pc_we   = !dec_legal;
          state_d = dec_legal ? EXEC : FETCH;
        end
        EXEC: begin
          alusrc_a = cls_q inside {C_AUIPC, C_JAL, C_BRANCH};
          alusrc_b = !(cls_q inside {C_OP, C_BRANCH});
          pc_we    = cls_q == C_BRANCH;
          pc_sel   = (cls_q == C_BRANCH && br_taken) ? PC_IMM : PC_PLUS4;
          state_d  = cls_q == C_BRANCH ? FETCH :
                     (cls_q == C_LOAD || cls_q == C_STORE) ? MEM : WB;
        end
        MEM: begin
          dmem_req = 1'b1;
          dmem_we  = cls_q == C_STORE;
          pc_we    = dmem_ack && cls_q == C_STORE;
          state_d  = !dmem_ack ? MEM : cls_q == C_STORE ? FETCH : WB;
        end
        WB: begin
          reg_we  = 1'b1;
          pc_we   = 1'b1;
          wb_sel  = cls_q == C_LOAD ? WB_MEM :
                    (cls_q == C_JAL || cls_q == C_JALR) ? WB_PC4 : WB_ALU;
          pc_sel  = cls_q == C_JAL ? PC_IMM : cls_q == C_JALR ? PC_ALU : PC_PLUS4;
          state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // stall counter saturates at the limit so the timeout fires only once per wait
  always_comb begin
    waiting     = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);
    stall_d     = !waiting ? 32'd0 : stall_q == 32'(STALL_LIMIT) ? stall_q : stall_q + 32'd1;
    mem_timeout = STALL_LIMIT != 0 && waiting && stall_q == 32'(STALL_LIMIT - 1);
  end

  // state, latched class/format and stall counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_STATE;
      cls_q   <= C_ILL;
      extop_q <= IMMI;
      stall_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      extop_q <= extop_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized scoreboard bench for the multicycle control FSM
module tb_multicycle_ctrl;
  typedef struct {
    int pc_sel, wb, reg_w, ill, ext, cyc, dcyc, dwe, a, b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0, br_taken = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, alusrc_a, alusrc_b, reg_we, illegal, mem_timeout;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  extop;

  int   compared = 0, mismatched = 0, done_cnt = 0, exp_done = 0;
  int   cur_idly = 0, cur_ddly = 0, iw = 0, dw = 0;
  bit   auto_ack = 0, noise = 0, mon_en = 0;
  int   in_txn = 0, cyc = 0, ir_at = 0, rcnt = 0, dcyc = 0, dwe = 0, ca = 0, cb = 0;
  exp_t q[$];
  logic [6:0] opl [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                          7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};

  multicycle_ctrl #(.STALL_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .br_taken(br_taken), .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .extop(extop), .alusrc_a(alusrc_a),
    .alusrc_b(alusrc_b), .reg_we(reg_we), .wb_sel(wb_sel), .illegal(illegal),
    .mem_timeout(mem_timeout)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t model(logic [31:0] ins, int id, int dd, bit br);
    exp_t e;
    e.pc_sel = 0; e.wb = -1; e.reg_w = 0; e.ill = 0; e.ext = 0;
    e.cyc = 4 + id; e.dcyc = 0; e.dwe = 0; e.a = 0; e.b = 1;
    case (ins[6:0])
      7'b0110111: begin e.ext = 1; e.reg_w = 1; e.wb = 0; end
      7'b0010111: begin e.ext = 1; e.a = 1; e.reg_w = 1; e.wb = 0; end
      7'b1101111: begin e.ext = 4; e.a = 1; e.reg_w = 1; e.wb = 2; e.pc_sel = 1; end
      7'b1100111: begin e.reg_w = 1; e.wb = 2; e.pc_sel = 2; end
      7'b1100011: begin e.ext = 3; e.a = 1; e.b = 0; e.pc_sel = br ? 1 : 0; e.cyc = 3 + id; end
      7'b0000011: begin e.reg_w = 1; e.wb = 1; e.cyc = 5 + id + dd; e.dcyc = dd + 1; end
      7'b0100011: begin e.ext = 2; e.cyc = 4 + id + dd; e.dcyc = dd + 1; e.dwe = 1; end
      7'b0010011: begin e.reg_w = 1; e.wb = 0; end
      7'b0110011: begin e.b = 0; e.reg_w = 1; e.wb = 0; end
      default:    begin e.ill = 1; e.cyc = 2 + id; e.a = -1; e.b = -1; end
    endcase
    return e;
  endfunction

  // memory responders: ack after the configured wait, random noise while idle
  initial forever begin
    @(negedge clk); #1;
    if (!auto_ack) continue;
    if (imem_req) begin
      imem_ack = (iw == cur_idly);
      iw = imem_ack ? 0 : iw + 1;
    end else begin
      iw = 0;
      imem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    if (dmem_req) begin
      dmem_ack = (dw == cur_ddly);
      dw = dmem_ack ? 0 : dw + 1;
    end else begin
      dw = 0;
      dmem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // monitor: gathers per-instruction observations, checks them when pc_we retires it
  initial forever begin
    exp_t e;
    @(negedge clk); #2;
    if (!mon_en || rst) begin in_txn = 0; continue; end
    chk("req_exclusive", int'(imem_req && dmem_req), 0);
    chk("no_timeout", int'(mem_timeout), 0);
    if (!in_txn && imem_req) begin
      in_txn = 1; cyc = 0; ir_at = -10; rcnt = 0; dcyc = 0; dwe = 0; ca = -1; cb = -1;
    end
    if (in_txn) begin
      cyc++;
      if (ir_we) ir_at = cyc;
      if (cyc == ir_at + 2) begin ca = int'(alusrc_a); cb = int'(alusrc_b); end
      rcnt += int'(reg_we);
      dcyc += int'(dmem_req);
      if (dmem_we) dwe = 1;
      if (pc_we) begin
        if (q.size() == 0) chk("unexpected_retire", 1, 0);
        else begin
          e = q.pop_front();
          chk("pc_sel", int'(pc_sel), e.pc_sel);
          chk("reg_we", int'(reg_we), e.reg_w);
          if (e.wb >= 0) chk("wb_sel", int'(wb_sel), e.wb);
          chk("illegal", int'(illegal), e.ill);
          chk("extop", int'(extop), e.ext);
          chk("latency", cyc, e.cyc);
          chk("reg_we_count", rcnt, e.reg_w);
          chk("dmem_req_cycles", dcyc, e.dcyc);
          chk("dmem_we", dwe, e.dwe);
          if (e.a >= 0) begin
            chk("alusrc_a", ca, e.a);
            chk("alusrc_b", cb, e.b);
          end
        end
        in_txn = 0;
        done_cnt++;
      end
    end
  end

  task automatic prep(logic [31:0] ins, int id, int dd, bit br);
    instr = ins; cur_idly = id; cur_ddly = dd; br_taken = br;
    q.push_back(model(ins, id, dd, br));
    exp_done = done_cnt + 1;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk); #3;
      if (done_cnt >= exp_done) begin ok = 1; break; end
    end
    if (!ok) begin
      compared++; mismatched++;
      $display("FAIL txn_timeout: instr %08h not retired within 80 cycles", instr);
      q.delete();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  task automatic run(logic [31:0] ins, int id, int dd, bit br);
    prep(ins, id, dd, br);
    wait_done();
  endtask

  initial begin
    int hi, to, to_at, k;
    logic [31:0] r;
    logic [6:0] op;
    repeat (2) begin
      @(negedge clk); #3;
      chk("rst_imem_req", int'(imem_req), 0);
      chk("rst_extop", int'(extop), 0);
      chk("rst_strobes", int'({ir_we, pc_we, reg_we, dmem_req, illegal}), 0);
    end
    @(negedge clk);
    prep(32'h00500093, 0, 0, 0);
    auto_ack = 1; mon_en = 1; rst = 1'b0;
    #3;
    chk("first_imem_req", int'(imem_req), 1);
    chk("first_extop", int'(extop), 0);
    wait_done();
    run(32'h00112223, 0, 3, 0);
    run(32'h00208463, 0, 0, 1);
    run(32'h00208463, 0, 0, 0);
    run(32'h008000EF, 0, 0, 0);
    run(32'h123450B7, 0, 0, 0);
    run(32'h0000007F, 0, 0, 0);
    noise = 1;
    for (int n = 0; n < 80; n++) begin
      r = $urandom();
      k = $urandom_range(0, 9);
      op = (k == 9) ? r[6:0] : opl[k];
      run({r[31:7], op}, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    noise = 0;
    @(negedge clk);
    mon_en = 0; auto_ack = 0; imem_ack = 1'b0; dmem_ack = 1'b0;
    instr = 32'h00012083;
    @(negedge clk); imem_ack = 1'b1;
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk); #3;
    chk("mem_dmem_req", int'(dmem_req), 1);
    rst = 1'b1;
    @(negedge clk); #3;
    chk("rst_mid_dmem_req", int'(dmem_req), 0);
    @(negedge clk);
    rst = 1'b0; dmem_ack = 1'b1;
    #3;
    chk("after_rst_imem_req", int'(imem_req), 1);
    chk("after_rst_dmem_req", int'(dmem_req), 0);
    @(negedge clk);
    dmem_ack = 1'b0;
    #3;
    chk("late_ack_ignored_req", int'(dmem_req), 0);
    chk("late_ack_still_fetch", int'(imem_req), 1);
    chk("late_ack_no_ir_we", int'(ir_we), 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    hi = 0; to = 0; to_at = -1;
    for (int c = 0; c < 10; c++) begin
      #3;
      hi += int'(imem_req);
      if (mem_timeout) begin to++; if (to_at < 0) to_at = c; end
      @(negedge clk);
    end
    chk("stall_imem_req_held", hi, 10);
    chk("stall_timeout_pulses", to, 1);
    chk("stall_timeout_cycle", to_at, 3);
    imem_ack = 1'b1;
    #3;
    chk("stall_ack_ir_we", int'(ir_we), 1);
    @(negedge clk);
    imem_ack = 1'b0;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the immediate generator select (extop).
- Also drives IR/PC/register-file write strobes, ALU operand selects and memory request handshakes.
- Sits between the instruction register, imm generator, ALU and the instruction/data memory ports.

Parameters:
- RESET_STATE, FETCH, FSM state entered on reset.
- STALL_LIMIT, 0, if nonzero: cycles a memory request may wait before the mem_timeout pulse; 0 disables the check.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  current instruction register contents.
- imem_ack  in  1  instruction memory data valid.
- dmem_ack  in  1  data memory access complete.
- br_taken  in  1  ALU branch-compare result, valid in EXEC.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (store).
- ir_we  out  1  load instruction register.
- pc_we  out  1  update PC.
- pc_sel  out  2  00 pc+4, 01 pc+imm, 10 (alu_result & ~1).
- extop  out  3  immediate format: 000 I, 001 U, 010 S, 011 B, 100 J.
- alusrc_a  out  1  0 rs1, 1 pc.
- alusrc_b  out  1  0 rs2, 1 imm.
- reg_we  out  1  register-file write.
- wb_sel  out  2  00 alu, 01 mem, 10 pc+4.
- illegal  out  1  one-cycle pulse on unsupported opcode.
- mem_timeout  out  1  one-cycle pulse on STALL_LIMIT expiry.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to FETCH; extop=000.
  - All strobes, requests and selects go to 0.
  - imem_req is 0 in the cycle after reset is applied.
  - imem_req asserts the first cycle rst is low.
- Reset mid-operation: any state returns to FETCH; an outstanding imem_req/dmem_req drops on the next cycle, and any later ack is ignored.
- FETCH:
  - imem_req=1 held until imem_ack.
  - In the ack cycle: ir_we=1, then next state DECODE.
  - Without ack, stay in FETCH.
- DECODE:
  - Classify instr[6:0]. Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
  - Register the class and extop: U for LUI/AUIPC; J for JAL; B for BRANCH; S for STORE; I for all others.
  - extop is held constant until the next DECODE.
  - Unknown opcode: illegal=1 for this cycle, pc_we=1, pc_sel=00, next state FETCH.
- EXEC:
  - alusrc_a=1 for AUIPC/JAL/BRANCH, else 0. alusrc_b=0 for OP/BRANCH, else 1.
  - BRANCH: pc_we=1, pc_sel=01 if br_taken else 00, then FETCH.
  - LOAD/STORE: go to MEM.
  - All others: go to WB.
- MEM:
  - dmem_req=1, and dmem_we=1 for STORE; both held until dmem_ack.
  - On ack, LOAD goes to WB.
  - On ack, STORE asserts pc_we=1, pc_sel=00, then FETCH.
- WB:
  - reg_we=1, pc_we=1, then next state FETCH.
  - wb_sel=01 for LOAD, 10 for JAL/JALR, else 00.
  - pc_sel=01 for JAL, 10 for JALR, else 00.
- Strobes (ir_we, pc_we, reg_we, illegal) are single-cycle.
- Acks arriving in the same cycle as a request are accepted, which gives zero-wait latency per instruction class:
  - BRANCH: 3 cycles.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR, STORE: 4 cycles.
  - LOAD: 5 cycles.
- An ack arriving while no request is asserted is ignored.
- Timeout (STALL_LIMIT≠0):
  - A counter runs while imem_req or dmem_req waits; it clears on ack or when the state changes.
  - Reaching STALL_LIMIT pulses mem_timeout once; the request stays asserted.
- At most one of imem_req/dmem_req is asserted in any cycle.

Decomposition:
- Shared package rv_ctrl_pkg:
  - Opcode constants.
  - extop encodings (IMMI=000, IMMU=001, IMMS=010, IMMB=011, IMMJ=100), also used by the imm generator.
  - State enum.
  - pc_sel and wb_sel enums.
  - Instruction-class enum.
- One sub-module, ctrl_opdecode: combinational opcode → {class, extop, legal}, reused by a future pipelined core.

Test Plan:
- rst=1 for 2 cycles, then release → imem_req=0 during reset; imem_req=1 in the first cycle after release; extop=000.
- ADDI 0x00500093 with zero-wait acks → ir_we, then DECODE extop=000, EXEC alusrc_b=1, WB reg_we=1 wb_sel=00 pc_we=1 pc_sel=00; 4 cycles total.
- SW 0x00112223 with dmem_ack delayed 3 cycles → extop=010; dmem_req=dmem_we=1 held for 4 cycles; then pc_we=1, no reg_we.
- BEQ 0x00208463 with br_taken=1, then repeat with br_taken=0 → extop=011; pc_sel=01 vs 00; 3 cycles each; reg_we never asserted.
- JAL 0x008000EF and LUI 0x123450B7 → extop=100 with wb_sel=10 pc_sel=01; extop=001 with wb_sel=00.
- instr=0x0000007F → illegal pulse in DECODE, pc_we pc_sel=00, back to FETCH.
- rst asserted mid-MEM with dmem_req=1 → dmem_req=0 next cycle, state FETCH; a late dmem_ack is ignored.
- STALL_LIMIT=4 with imem_ack withheld for 10 cycles → exactly one mem_timeout pulse; imem_req stays high.
